// File: rtl/motor_duty_sequencer_pkg.sv
// Shared types for the motor duty sequencer:
// FSM state codes, duty width, PWM period length.
package fc_pkg;

   localparam int DUTY_W = 8;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'b00,
      ST_ARMING   = 2'b01,
      ST_ARMED    = 2'b10,
      ST_FAILSAFE = 2'b11
   } fc_state_e;

   function automatic int max_count(
      input int clk_freq,
      input int pwm_freq
   );
      return clk_freq / pwm_freq;
   endfunction

endpackage

// File: rtl/motor_duty_sequencer_if.sv
// Command handshake bundle from the flight loop.
// master: drives cmd_valid/cmd_duty; slave: drives cmd_ready.
interface motor_duty_sequencer_if #(
   parameter int NUM_MOTORS = 4
);
   import fc_pkg::*;

   logic                         cmd_valid;
   logic                         cmd_ready;
   logic [DUTY_W*NUM_MOTORS-1:0] cmd_duty;

   modport master (
      output cmd_valid,
      output cmd_duty,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_duty,
      output cmd_ready
   );

endinterface

// File: rtl/motor_duty_sequencer_slew_limiter.sv
// One duty channel: steps toward target by <= SLEW_STEP per tick.
// in: clk, reset_n, tick, load, load_val, target; out: duty.
module slew_limiter
   import fc_pkg::*;
#(
   parameter int SLEW_STEP = 2
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick,
   input  logic              load,
   input  logic [DUTY_W-1:0] load_val,
   input  logic [DUTY_W-1:0] target,
   output logic [DUTY_W-1:0] duty
);

   localparam int W = DUTY_W + 2;
   localparam logic signed [W-1:0] STEP_P = W'(SLEW_STEP);
   localparam logic signed [W-1:0] STEP_N = -STEP_P;

   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic signed [W-1:0] diff, step, sum;

   always_comb begin
      diff = $signed({2'b00, target}) - $signed({2'b00, duty_q});
      step = diff;
      if (diff > STEP_P) step = STEP_P;
      if (diff < STEP_N) step = STEP_N;
      sum = $signed({2'b00, duty_q}) + step;
      duty_d = duty_q;
      if (load) begin
         duty_d = load_val;
      end else if (tick) begin
         // sign bit -> below 0, bit 8 -> above 255
         if (sum[W-1])      duty_d = '0;
         else if (sum[W-2]) duty_d = '1;
         else               duty_d = sum[DUTY_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) duty_q <= '0;
      else          duty_q <= duty_d;
   end

   assign duty = duty_q;

endmodule

// File: rtl/motor_duty_sequencer.sv
// ESC arming/failsafe sequencer in front of the PWM generators.
// in: clk, reset_n, arm_req, cmd (slave); out: duty_out, period_tick,
// armed, failsafe, state.
module motor_duty_sequencer
   import fc_pkg::*;
#(
   parameter int CLK_FREQ        = 100000000,
   parameter int PWM_FREQ        = 20000,
   parameter int NUM_MOTORS      = 4,
   parameter int ARM_PERIODS     = 2000,
   parameter int TIMEOUT_PERIODS = 2000,
   parameter int SLEW_STEP       = 2,
   parameter int IDLE_DUTY       = 20
)(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         arm_req,
   motor_duty_sequencer_if.slave        cmd,
   output logic [DUTY_W*NUM_MOTORS-1:0] duty_out,
   output logic                         period_tick,
   output logic                         armed,
   output logic                         failsafe,
   output logic [1:0]                   state
);

   localparam int MAX_COUNT = max_count(CLK_FREQ, PWM_FREQ);
   localparam int CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
   localparam int ARM_W = $clog2(ARM_PERIODS + 1);
   localparam int WD_W  = $clog2(TIMEOUT_PERIODS + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_COUNT - 1);
   localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_PERIODS - 1);
   localparam logic [WD_W-1:0]   WD_TO    = WD_W'(TIMEOUT_PERIODS);
   localparam logic [DUTY_W-1:0] IDLE_D   = DUTY_W'(IDLE_DUTY);

   typedef logic [NUM_MOTORS-1:0][DUTY_W-1:0] duty_vec_t;

   fc_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [ARM_W-1:0] arm_cnt_q;
   logic [WD_W-1:0]  wd_q, wd_inc;
   logic             arm_prev_q;
   logic             fs_q;
   duty_vec_t        tgt_q;
   duty_vec_t        cmd_clamp;
   duty_vec_t        duty_w;

   logic tick, accept, rise, all_idle;
   logic go_dis, go_armed, go_fs;
   logic slew_tick, slew_load;
   logic [DUTY_W-1:0] slew_val;

   always_comb begin
      tick     = (cnt_q == CNT_LAST);
      accept   = cmd.cmd_valid && (state_q == ST_ARMED);
      rise     = arm_req && !arm_prev_q;
      wd_inc   = wd_q + 1'b1;
      all_idle = 1'b1;
      for (int i = 0; i < NUM_MOTORS; i++) begin
         if (duty_w[i] != IDLE_D) all_idle = 1'b0;
         cmd_clamp[i] = cmd.cmd_duty[i*DUTY_W +: DUTY_W];
         if (cmd_clamp[i] < IDLE_D) cmd_clamp[i] = IDLE_D;
      end
      // dropping arm_req outranks every other transition
      go_dis = (state_q != ST_DISARMED) &&
               (!arm_req ||
                ((state_q == ST_FAILSAFE) && tick && all_idle));
      go_armed = (state_q == ST_ARMING) && arm_req && tick &&
                 (arm_cnt_q == ARM_LAST);
      // an accept on the timeout tick keeps us ARMED
      go_fs = (state_q == ST_ARMED) && arm_req && tick &&
              !accept && (wd_inc == WD_TO);
      slew_tick = tick && ((state_q == ST_ARMED) ||
                           (state_q == ST_FAILSAFE));
      slew_load = go_dis || go_armed;
      slew_val  = go_armed ? IDLE_D : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_DISARMED;
         cnt_q      <= '0;
         arm_cnt_q  <= '0;
         wd_q       <= '0;
         arm_prev_q <= 1'b0;
         fs_q       <= 1'b0;
         tgt_q      <= {NUM_MOTORS{IDLE_D}};
      end else begin
         cnt_q      <= tick ? '0 : cnt_q + 1'b1;
         arm_prev_q <= arm_req;
         if (go_dis) begin
            state_q   <= ST_DISARMED;
            arm_cnt_q <= '0;
            wd_q      <= '0;
            tgt_q     <= {NUM_MOTORS{IDLE_D}};
         end else begin
            unique case (state_q)
               ST_DISARMED: begin
                  if (rise) begin
                     state_q   <= ST_ARMING;
                     fs_q      <= 1'b0;
                     arm_cnt_q <= '0;
                  end
               end
               ST_ARMING: begin
                  if (go_armed) begin
                     state_q <= ST_ARMED;
                     wd_q    <= '0;
                     tgt_q   <= {NUM_MOTORS{IDLE_D}};
                  end else if (tick) begin
                     arm_cnt_q <= arm_cnt_q + 1'b1;
                  end
               end
               ST_ARMED: begin
                  if (accept) begin
                     tgt_q <= cmd_clamp;
                     wd_q  <= '0;
                  end else if (go_fs) begin
                     state_q <= ST_FAILSAFE;
                     fs_q    <= 1'b1;
                     wd_q    <= '0;
                     tgt_q   <= {NUM_MOTORS{IDLE_D}};
                  end else if (tick) begin
                     wd_q <= wd_inc;
                  end
               end
               ST_FAILSAFE: begin
                  tgt_q <= {NUM_MOTORS{IDLE_D}};
               end
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
      slew_limiter #(
         .SLEW_STEP (SLEW_STEP)
      ) u_slew (
         .clk      (clk),
         .reset_n  (reset_n),
         .tick     (slew_tick),
         .load     (slew_load),
         .load_val (slew_val),
         .target   (tgt_q[g]),
         .duty     (duty_w[g])
      );
   end

   assign duty_out      = duty_w;
   assign period_tick   = tick;
   assign armed         = (state_q == ST_ARMED);
   assign failsafe      = fs_q;
   assign state         = state_q;
   assign cmd.cmd_ready = (state_q == ST_ARMED);

endmodule
